data_memory_arbiter: RTL
========================

# data_memory_arbiter

Two-port arbiter that shares the single data-memory controller port between the DLX load/store unit (port 0) and a secondary master such as debug/DMA (port 1). Each accepted request is latched and presented to the memory controller, then held until the controller acknowledges it or a watchdog expires. Completion goes back to the owning requester as a one-cycle ready pulse with read data and an error flag. The block sits between the core/debug masters and the data memory controller.

## Interface
- DATA_WIDTH, 32, data bus width
- DATA_ADDR_WIDTH, 32, address bus width
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without ack before error completion; 0 disables the watchdog; 8-bit counter, legal range 0..255
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_rd_en / m1_rd_en  input  1  read request, held until the port's ready
- m0_wr_en / m1_wr_en  input  1  write request, held until the port's ready
- m0_addr / m1_addr  input  DATA_ADDR_WIDTH  request address
- m0_data_wr / m1_data_wr  input  DATA_WIDTH  write data
- m0_data_rd / m1_data_rd  output  DATA_WIDTH  read data, valid while the port's ready is high
- m0_ready / m1_ready  output  1  one-cycle completion pulse
- m0_err / m1_err  output  1  timeout flag, valid with ready
- mem_rd_en  output  1  read command to memory controller
- mem_wr_en  output  1  write command to memory controller
- mem_addr  output  DATA_ADDR_WIDTH  latched address
- mem_data_wr  output  DATA_WIDTH  latched write data
- mem_data_rd  input  DATA_WIDTH  read data from controller, valid with mem_ack
- mem_ack  input  1  controller completion, one or more cycles

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: port p requests when its rd_en or wr_en is high. If only one port requests, grant it. If both request, grant the port opposite last_grant. last_grant resets to 1, so port 0 wins the first tie. On grant, latch addr, data_wr and op; update last_grant; go to BUSY.
- op: when rd_en and wr_en are both high, the request is a write.
- BUSY: mem_rd_en or mem_wr_en (per latched op) is held high, with mem_addr and mem_data_wr stable, every cycle until exit.
  - mem_ack high: capture mem_data_rd (reads only; writes return 0), clear err, go to RESP.
  - Timeout: when TIMEOUT_CYCLES != 0 and the wait counter reaches TIMEOUT_CYCLES with no ack, set err, load 0 as read data, go to RESP.
- RESP: the granted port's ready is high for exactly one cycle, with data_rd and err. The other port's outputs stay 0. Return to IDLE.
- mem_ack in IDLE or RESP is ignored.
- Request inputs are not re-sampled during BUSY or RESP. A requester's changes there have no effect.
- The requester must drop its request in the cycle after ready. A request still high in IDLE is treated as a new request.
- Reset mid-operation: abort any transaction. All outputs go to 0 immediately (asynchronous), state goes to IDLE, last_grant to 1, counter to 0. No ready is issued for the aborted transaction.

## Timing
- Reset values: all outputs 0 (mem_rd_en, mem_wr_en, mem_addr, mem_data_wr, m*_ready, m*_data_rd, m*_err).
- Request sampled at edge N in IDLE: mem_*_en high from cycle N+1.
- First ack sampled at edge N+k (k≥1): enables low and ready high in cycle N+k+1. Minimum request-to-ready is 2 cycles.
- IDLE is re-entered at cycle N+k+2, so the next grant is sampled at edge N+k+2. Back-to-back throughput is one transaction per k+2 cycles.
- Watchdog: the counter clears on grant and increments each BUSY cycle without ack. Timeout is detected when counter == TIMEOUT_CYCLES. Enables stay high for exactly TIMEOUT_CYCLES cycles, then ready and err are high together.
- Ack and timeout in the same cycle: ack wins, err = 0.
- Held ack (multi-cycle) produces exactly one completion.

## Test plan
- Single read on port 0: addr 0x100, ack after 3 cycles with mem_data_rd 0xDEADBEEF. Required: mem_rd_en high 3 cycles; m0_ready one cycle with m0_data_rd 0xDEADBEEF and m0_err 0; m1_ready never asserts.
- Simultaneous requests: port 0 writes 0x10/0xA5A5A5A5, port 1 reads 0x20, ack latency 1 each. Required grant order: port 0 then port 1. Both ports then re-request together: order is port 0, then port 1 again (alternation).
- rd_en and wr_en both high on port 1: mem_wr_en asserted, mem_rd_en stays 0, m1_data_rd = 0 at ready.
- Timeout with TIMEOUT_CYCLES = 4 and no ack: mem_rd_en high exactly 4 cycles, then m0_ready and m0_err high together with data 0. Repeat with TIMEOUT_CYCLES = 0: waits indefinitely, completes on ack after 300 cycles with err 0.
- Ack in the same cycle as the timeout: err 0. Ack held high 5 cycles: exactly one ready. Spurious ack in IDLE: no ready.
- Assert rst_n low during BUSY: outputs 0 asynchronously and no ready. After release, a port 0 + port 1 tie grants port 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin arbiter in front of the data-memory controller
module data_memory_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m0_rd_en,
  input  logic                       m0_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]      m0_data_wr,
  output logic [DATA_WIDTH-1:0]      m0_data_rd,
  output logic                       m0_ready,
  output logic                       m0_err,
  input  logic                       m1_rd_en,
  input  logic                       m1_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]      m1_data_wr,
  output logic [DATA_WIDTH-1:0]      m1_data_rd,
  output logic                       m1_ready,
  output logic                       m1_err,
  output logic                       mem_rd_en,
  output logic                       mem_wr_en,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data_wr,
  input  logic [DATA_WIDTH-1:0]      mem_data_rd,
  input  logic                       mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Watchdog compare is done one bit wider so TIMEOUT_CYCLES = 255 is reachable by cnt+1.
  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT_CYCLES);
  localparam bit         LP_WD_EN   = (TIMEOUT_CYCLES != 0);

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_last_grant;
  logic                       r_grant;
  logic                       r_op_wr;
  logic [DATA_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]      r_data_wr;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic                       r_err;
  logic [7:0]                 r_cnt;

  logic                       w_req0;
  logic                       w_req1;
  logic                       w_grant_port;
  logic [8:0]                 w_cnt_inc;
  logic                       w_timeout;
  logic                       w_busy;
  logic                       w_resp;

  assign w_req0    = m0_rd_en | m0_wr_en;
  assign w_req1    = m1_rd_en | m1_wr_en;
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  // Fires on the last allowed BUSY cycle so the enables stay up exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = LP_WD_EN && (w_cnt_inc == LP_TIMEOUT);
  assign w_busy    = (r_state == S_BUSY);
  assign w_resp    = (r_state == S_RESP);

  // Pick the requester: a lone requester wins, a tie goes opposite the last grant.
  always_comb begin
    w_grant_port = 1'b0;
    if (w_req0 && w_req1) begin
      w_grant_port = ~r_last_grant;
    end else if (w_req1) begin
      w_grant_port = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; ack takes priority over the watchdog.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_req0 || w_req1) w_state_next = S_BUSY;
      S_BUSY: if (mem_ack || w_timeout) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, watchdog counter and completion capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op_wr      <= 1'b0;
      r_addr       <= '0;
      r_data_wr    <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (r_state == S_IDLE && (w_req0 || w_req1)) begin
        r_grant      <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_op_wr      <= w_grant_port ? m1_wr_en : m0_wr_en;
        r_addr       <= w_grant_port ? m1_addr : m0_addr;
        r_data_wr    <= w_grant_port ? m1_data_wr : m0_data_wr;
        r_cnt        <= '0;
      end else if (w_busy) begin
        if (mem_ack) begin
          r_rdata <= r_op_wr ? '0 : mem_data_rd;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign mem_rd_en   = w_busy & ~r_op_wr;
  assign mem_wr_en   = w_busy & r_op_wr;
  assign mem_addr    = r_addr;
  assign mem_data_wr = r_data_wr;

  assign m0_ready   = w_resp & ~r_grant;
  assign m1_ready   = w_resp & r_grant;
  assign m0_data_rd = {DATA_WIDTH{m0_ready}} & r_rdata;
  assign m1_data_rd = {DATA_WIDTH{m1_ready}} & r_rdata;
  assign m0_err     = m0_ready & r_err;
  assign m1_err     = m1_ready & r_err;

endmodule
